// File: rtl/bin2bcd_serial_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : bin2bcd_serial_if
// Purpose : Request/result bundle for bin2bcd_serial; seg only with BIN2BCD_SEG_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface bin2bcd_serial_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_SEG_EN
  logic [7*DIGITS-1:0]   seg;

  modport master (output start, bin, input busy, done, bcd, seg);
  modport slave  (input start, bin, output busy, done, bcd, seg);
`else
  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface
`default_nettype wire

// File: rtl/bin2bcd_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : bin2bcd_serial
// Purpose : Double-dabble binary-to-BCD converter, one bit per clock.
//           Optional seven-segment output enabled by macro BIN2BCD_SEG_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bin2bcd_serial #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  wire logic          clk,
  input  wire logic          reset,
  bin2bcd_serial_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      shreg;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   bcd_q;
  logic                  busy_q;
  logic                  done_q;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   next_scratch;
  logic [WIDTH-1:0]      next_shift;
  logic                  last_step;

  // Adjust every digit >= 5, then shift {scratch, shreg} left by one.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    next_scratch = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
    next_shift   = {shreg[WIDTH-2:0], 1'b0};
  end

  assign last_step = (state == CONVERT) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      scratch <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= bus.bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch <= next_scratch;
          shreg   <= next_shift;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_q  <= next_scratch;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

`ifdef BIN2BCD_SEG_EN
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  logic [7*DIGITS-1:0] seg_next;
  logic [7*DIGITS-1:0] seg_q;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      assign seg_next[7*g +: 7] = seg7(next_scratch[4*g +: 4]);
    end
  endgenerate

  // Decoded from the same value that lands in bcd, so both update together.
  always_ff @(posedge clk) begin
    if (reset)
      seg_q <= {DIGITS{7'h3F}};
    else if (last_step)
      seg_q <= seg_next;
  end

  assign bus.seg = seg_q;
`else
  logic unused_last_step;
  assign unused_last_step = last_step;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_serial.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_bin2bcd_serial
// Purpose : Directed self-checking bench for bin2bcd_serial (16-bit, 5 digits).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bin2bcd_serial;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  int   cycles;
  int   dones;

  bin2bcd_serial_if #(.WIDTH(16), .DIGITS(5)) bus ();

  bin2bcd_serial #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start edge then wait (bounded) for done; cycles counts edges after E0.
  task automatic convert(input logic [15:0] val);
    bus.start = 1'b1;
    bus.bin   = val;
    tick();
    bus.start = 1'b0;
    bus.bin   = 16'hDEAD;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  logic [15:0] vec_bin [6];
  logic [19:0] vec_bcd [6];

  initial begin
    compared   = 0;
    mismatched = 0;
    bus.start  = 1'b0;
    bus.bin    = '0;
    vec_bin[0] = 16'd1;     vec_bcd[0] = 20'h00001;
    vec_bin[1] = 16'd9;     vec_bcd[1] = 20'h00009;
    vec_bin[2] = 16'd10;    vec_bcd[2] = 20'h00010;
    vec_bin[3] = 16'd4095;  vec_bcd[3] = 20'h04095;
    vec_bin[4] = 16'd40960; vec_bcd[4] = 20'h40960;
    vec_bin[5] = 16'd59999; vec_bcd[5] = 20'h59999;

    // Reset, then idle
    reset = 1'b1;
    tick();
    tick();
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_bcd",  64'(bus.bcd),  64'd0);
`ifdef BIN2BCD_SEG_EN
    check("reset_seg",  64'(bus.seg),  64'({5{7'h3F}}));
`endif
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_state", {bus.busy, bus.done, bus.bcd}, 64'd0);
    end

    // Basic conversions
    convert(16'd12345);
    check("c12345_lat", 64'(cycles), 64'd16);
    check("c12345_bcd", 64'(bus.bcd), 64'h12345);
    check("c12345_busy", 64'(bus.busy), 64'd0);
    tick();
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("bcd_hold", 64'(bus.bcd), 64'h12345);

    convert(16'd0);
    check("c0_lat", 64'(cycles), 64'd16);
    check("c0_bcd", 64'(bus.bcd), 64'h00000);
    tick();

    convert(16'd65535);
    check("c65535_lat", 64'(cycles), 64'd16);
    check("c65535_bcd", 64'(bus.bcd), 64'h65535);
    tick();

    for (int k = 0; k < 6; k++) begin
      convert(vec_bin[k]);
      check("vec_lat", 64'(cycles), 64'd16);
      check("vec_bcd", 64'(bus.bcd), 64'(vec_bcd[k]));
      tick();
    end

    // Start while busy is ignored
    bus.start = 1'b1;
    bus.bin   = 16'd9999;
    tick();
    bus.start = 1'b0;
    cycles = 0;
    dones  = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cycles++;
    end
    bus.start = 1'b1;
    bus.bin   = 16'd1;
    tick();
    cycles++;
    bus.start = 1'b0;
    while (!bus.done && cycles < 40) begin
      tick();
      cycles++;
    end
    check("busy_start_lat", 64'(cycles), 64'd16);
    check("busy_start_bcd", 64'(bus.bcd), 64'h09999);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) dones++;
    end
    check("no_second_done", 64'(dones), 64'd0);
    check("no_second_busy", 64'(bus.busy), 64'd0);
    check("no_second_bcd", 64'(bus.bcd), 64'h09999);

    // Back-to-back start in the done cycle
    convert(16'd9999);
    check("b2b_first_bcd", 64'(bus.bcd), 64'h09999);
    check("b2b_busy_low", 64'(bus.busy), 64'd0);
    convert(16'd10000);
    check("b2b_second_lat", 64'(cycles), 64'd16);
    check("b2b_second_bcd", 64'(bus.bcd), 64'h10000);
    tick();

    // Reset mid-conversion
    bus.start = 1'b1;
    bus.bin   = 16'd54321;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_bcd",  64'(bus.bcd),  64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    check("midrst_quiet", 64'(dones), 64'd0);
    convert(16'd42);
    check("after_rst_lat", 64'(cycles), 64'd16);
    check("after_rst_bcd", 64'(bus.bcd), 64'h00042);
    tick();

`ifdef BIN2BCD_SEG_EN
    bus.start = 1'b1;
    bus.bin   = 16'd1234;
    tick();
    bus.start = 1'b0;
    check("seg_hold", 64'(bus.seg), 64'({7'h3F, 7'h3F, 7'h3F, 7'h66, 7'h5B}));
    cycles = 0;
    while (!bus.done && cycles < 40) begin
      tick();
      cycles++;
    end
    check("seg_bcd", 64'(bus.bcd), 64'h01234);
    check("seg_1234", 64'(bus.seg), 64'({7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
